// File: rtl/expr_result_pkg.sv
// Field layout of the 90-bit packed expression-result bus {y0,...,y17}, y0 at the MSB.
// Shared by the unpacker top and its field extractor.
package expr_result_pkg;

  localparam int NUM_FIELDS = 18;
  localparam int PACKED_W   = 90;

  typedef logic [4:0] field_idx_t;

  // Fields repeat in groups of three (widths 4,5,6); every second group is signed.
  function automatic int field_width(input field_idx_t k);
    return 4 + (int'(k) % 3);
  endfunction

  function automatic logic field_signed(input field_idx_t k);
    return (int'(k) % 6) >= 3;
  endfunction

  function automatic int field_msb(input field_idx_t k);
    int r;
    r = int'(k) % 3;
    return PACKED_W - 1 - 15 * (int'(k) / 3) - ((r == 0) ? 0 : (r == 1) ? 4 : 9);
  endfunction

endpackage

// File: rtl/expr_field_extract.sv
// Combinational slice of one field from the packed word, sign- or zero-extended to OUT_W.
// With EXPR_UNPACK_SIG_EN defined it also exposes the raw (unextended) field bits.
module expr_field_extract
  import expr_result_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [PACKED_W-1:0] i_word,
  input  field_idx_t          i_idx,
`ifdef EXPR_UNPACK_SIG_EN
  output logic [5:0]          o_raw,
`endif
  output logic [OUT_W-1:0]    o_field,
  output logic                o_signed
);

  logic [5:0] w_bits;
  logic [5:0] w_raw;
  logic [5:0] w_mask;
  logic       w_top;
  logic       w_fill;

  always_comb begin
    w_bits   = 6'(i_word >> (field_msb(i_idx) - field_width(i_idx) + 1));
    o_signed = field_signed(i_idx);
    case (field_width(i_idx))
      4:       begin w_mask = 6'h0F; w_top = w_bits[3]; end
      5:       begin w_mask = 6'h1F; w_top = w_bits[4]; end
      default: begin w_mask = 6'h3F; w_top = w_bits[5]; end
    endcase
    w_raw  = w_bits & w_mask;
    w_fill = o_signed & w_top;
    // Bits above the field width carry the fill value, both inside and beyond bit 5.
    o_field = OUT_W'(w_raw | (w_fill ? ~w_mask : 6'h00));
    for (int b = 6; b < OUT_W; b++) o_field[b] = w_fill;
  end

`ifdef EXPR_UNPACK_SIG_EN
  assign o_raw = w_raw;
`endif

endmodule

// File: rtl/expr_result_unpacker.sv
// Unpacks one 90-bit expression-result word into 18 extended field beats (valid/ready both sides).
// Optional EXPR_UNPACK_SIG_EN adds a per-word rotate-xor signature on sig_out/sig_valid.
module expr_result_unpacker
  import expr_result_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PACKED_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          out_idx,
  output logic [OUT_W-1:0]    out_field,
  output logic                out_signed,
  output logic                out_last
`ifdef EXPR_UNPACK_SIG_EN
  ,
  output logic [15:0]         sig_out,
  output logic                sig_valid
`endif
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  localparam field_idx_t FIRST_IDX = MSB_FIRST ? field_idx_t'(0) : field_idx_t'(NUM_FIELDS - 1);
  localparam field_idx_t LAST_IDX  = MSB_FIRST ? field_idx_t'(NUM_FIELDS - 1) : field_idx_t'(0);

  state_t              r_state;
  field_idx_t          r_cnt;
  logic [PACKED_W-1:0] r_word;
  logic                w_at_last;
  logic                w_in_hs;
  logic                w_out_hs;

  assign out_valid = (r_state == S_EMIT);
  assign out_idx   = r_cnt;
  assign w_at_last = (r_cnt == LAST_IDX);
  assign out_last  = out_valid && w_at_last;
  // Accepting during the last beat lets the next word follow with no bubble.
  assign in_ready  = (r_state == S_IDLE) || (w_at_last && out_ready);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

`ifdef EXPR_UNPACK_SIG_EN
  logic [5:0] w_raw;
`endif

  expr_field_extract #(.OUT_W(OUT_W)) u_extract (
    .i_word   (r_word),
    .i_idx    (r_cnt),
`ifdef EXPR_UNPACK_SIG_EN
    .o_raw    (w_raw),
`endif
    .o_field  (out_field),
    .o_signed (out_signed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_word  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_hs) begin
            r_word  <= in_data;
            r_cnt   <= FIRST_IDX;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (w_out_hs) begin
            if (!w_at_last) begin
              r_cnt <= MSB_FIRST ? r_cnt + 5'd1 : r_cnt - 5'd1;
            end else if (w_in_hs) begin
              r_word <= in_data;
              r_cnt  <= FIRST_IDX;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef EXPR_UNPACK_SIG_EN
  logic [15:0] r_sig;
  logic [15:0] w_sig_next;

  assign w_sig_next = {r_sig[14:0], r_sig[15]} ^ {10'b0, w_raw};

  // sig_out captures the folded value including the last field, so it is valid even when a new word loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig     <= '0;
      sig_out   <= '0;
      sig_valid <= 1'b0;
    end else begin
      sig_valid <= w_out_hs && w_at_last;
      if (w_out_hs && w_at_last) sig_out <= w_sig_next;
      if (w_in_hs)       r_sig <= '0;
      else if (w_out_hs) r_sig <= w_sig_next;
    end
  end
`endif

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Bench for expr_result_unpacker: directed and random words against a field-list reference model.
// Exercises the EXPR_UNPACK_SIG_EN signature when that macro is defined.
module tb_expr_result_unpacker;

  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [89:0]   in_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    out_idx;
  logic [OW-1:0] out_field;
  logic          out_signed;
  logic          out_last;
`ifdef EXPR_UNPACK_SIG_EN
  logic [15:0]   sig_out;
  logic          sig_valid;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;
  int c1;
  int fld[4][18];

  expr_result_unpacker #(.OUT_W(OW), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_field  (out_field),
    .out_signed (out_signed),
    .out_last   (out_last)
`ifdef EXPR_UNPACK_SIG_EN
    ,
    .sig_out    (sig_out),
    .sig_valid  (sig_valid)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: fields are kept as plain integers and packed by concatenation.
  function automatic int fw(input int k);
    return 4 + k % 3;
  endfunction

  function automatic bit fs(input int k);
    return (k % 6) >= 3;
  endfunction

  function automatic logic [89:0] pack(input int s);
    logic [89:0] w;
    w = '0;
    for (int k = 0; k < 18; k++) w = (w << fw(k)) | 90'(fld[s][k]);
    return w;
  endfunction

  function automatic int exp_ext(input int s, input int k);
    int v;
    v = fld[s][k];
    if (fs(k) && v >= (1 << (fw(k) - 1))) v = v - (1 << fw(k));
    return v & ((1 << OW) - 1);
  endfunction

  function automatic int sig_of(input int s);
    int g;
    g = 0;
    for (int k = 0; k < 18; k++) g = ((((g << 1) | (g >> 15)) & 16'hFFFF) ^ fld[s][k]);
    return g;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int s, input int v);
    for (int k = 0; k < 18; k++) fld[s][k] = v;
  endtask

  task automatic rnd_fill(input int s);
    for (int k = 0; k < 18; k++) fld[s][k] = int'($urandom_range((1 << fw(k)) - 1, 0));
  endtask

  // Called at a falling edge with the DUT idle; returns at the falling edge showing beat 0.
  task automatic start(input int s);
    in_data  = pack(s);
    in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '1;
  endtask

  task automatic drain(input int s, input int stall_k, input int stall_n, input int stop_k);
    for (int k = 0; k < 18; k++) begin
      if (k == stop_k) return;
      check("out_valid", 32'(out_valid), 1);
      check("out_idx", 32'(out_idx), k);
      check("out_field", 32'(out_field), exp_ext(s, k));
      check("out_signed", 32'(out_signed), int'(fs(k)));
      check("out_last", 32'(out_last), (k == 17) ? 1 : 0);
      check("in_ready_emit", 32'(in_ready), (k == 17) ? 1 : 0);
`ifdef EXPR_UNPACK_SIG_EN
      if (k > 0) check("sig_valid_quiet", 32'(sig_valid), 0);
`endif
      if (k == stall_k) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          check("stall_valid", 32'(out_valid), 1);
          check("stall_idx", 32'(out_idx), k);
          check("stall_field", 32'(out_field), exp_ext(s, k));
          check("stall_last", 32'(out_last), (k == 17) ? 1 : 0);
          check("stall_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
`ifdef EXPR_UNPACK_SIG_EN
    check("sig_valid_pulse", 32'(sig_valid), 1);
    check("sig_out", 32'(sig_out), sig_of(s));
`endif
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_last"}, 32'(out_last), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_idx", 32'(out_idx), 0);
    check("reset_field", 32'(out_field), 0);
    check("reset_signed", 32'(out_signed), 0);
`ifdef EXPR_UNPACK_SIG_EN
    check("reset_sig_valid", 32'(sig_valid), 0);
    check("reset_sig_out", 32'(sig_out), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // y0 = 4'hA (unsigned), y3 = 4'b1000 (signed, -8), everything else zero.
    set_all(0, 0);
    fld[0][0] = 10;
    fld[0][3] = 8;
    start(0);
    drain(0, -1, 0, -1);
    check_idle("after_directed");

    // All ones: 0F/1F/3F for unsigned groups, FF for signed groups.
    set_all(1, 0);
    for (int k = 0; k < 18; k++) fld[1][k] = (1 << fw(k)) - 1;
    start(1);
    drain(1, -1, 0, -1);
    check_idle("after_ones");

    // Backpressure for 5 cycles at idx7.
    rnd_fill(2);
    @(negedge clk);
    start(2);
    drain(2, 7, 5, -1);
    check_idle("after_stall");

    // Back-to-back words with in_valid held high.
    rnd_fill(0);
    rnd_fill(1);
    in_data  = pack(0);
    in_valid = 1'b1;
    check("b2b_in_ready", 32'(in_ready), 1);
    @(negedge clk);
    in_data = pack(1);
    c1 = cyc;
    drain(0, -1, 0, -1);
    check("b2b_gap", 32'(cyc - c1), 18);
    in_valid = 1'b0;
    in_data  = '1;
    drain(1, -1, 0, -1);
    check_idle("after_b2b");

    // Reset mid-word at idx9, then a fresh word.
    rnd_fill(2);
    start(2);
    drain(2, -1, 0, 9);
    rst_n = 1'b0;
    #1;
    check_idle("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("midrst_rel");
    check("midrst_idx", 32'(out_idx), 0);
`ifdef EXPR_UNPACK_SIG_EN
    check("midrst_sig_out", 32'(sig_out), 0);
`endif
    @(negedge clk);
    check_idle("midrst_quiet");
    rnd_fill(3);
    start(3);
    drain(3, -1, 0, -1);
    check_idle("after_midrst");

    // All-zero word and a word with only y17 = 1.
    set_all(0, 0);
    @(negedge clk);
    start(0);
    drain(0, -1, 0, -1);
    set_all(1, 0);
    fld[1][17] = 1;
    @(negedge clk);
    start(1);
    drain(1, -1, 0, -1);
    check_idle("after_sparse");

    // Random words with random stalls.
    for (int n = 0; n < 4; n++) begin
      rnd_fill(n);
      @(negedge clk);
      start(n);
      drain(n, int'($urandom_range(17, 0)), int'($urandom_range(3, 1)), -1);
      check_idle("after_random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
